serial_word_rx: RTL and testbench

Serial word receiver: the read side of a single-bit data line driven one bit per strobe. It recognises a start bit, shifts in `DATA_W` data bits, checks a stop bit, and presents the word on a one-entry valid/ready output buffer. It sits between a bit-level serial source, such as a flip-flop-driven line or serializer, and any parallel consumer.

---
 rtl/serial_pkg.sv | 25 ++
 rtl/rx_out_buf.sv | 58 +++++
 rtl/serial_word_rx.sv | 138 +++++++++++++
 tb/tb_serial_word_rx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared constants for the serial word link (receiver today, transmitter later).
//
// Contents:
//   rx_state_e           - receiver/transmitter frame FSM encoding
//   START_LVL, STOP_LVL  - line levels of the framing bits
//   IDLE_LVL             - level the line rests at between frames
//   frame_strobes()      - strobes per minimum-length frame for a given word width
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } rx_state_e;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // Start bit + data bits + stop bit.
  function automatic int unsigned frame_strobes(input int unsigned data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/rx_out_buf.sv
// Single-entry valid/ready output register for the serial receiver.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   load         - write data_in into the buffer (honoured only when can_load=1)
//   data_in      - word to store
//   can_load     - buffer is empty or is being drained on this edge
//   dout         - stored word, valid while dout_valid=1
//   dout_valid   - buffer holds a word
//   dout_ready   - consumer takes the word on an edge with dout_valid=1
module rx_out_buf
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic              can_load,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              xfer;

  assign xfer     = valid_q & dout_ready;
  // A full buffer can still take a word when it is emptied on the same edge.
  assign can_load = ~valid_q | dout_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load && can_load) begin
      valid_d = 1'b1;
      data_d  = data_in;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign dout       = data_q;
  assign dout_valid = valid_q;

endmodule

// File: rtl/serial_word_rx.sv
// Serial word receiver: detects a start bit, shifts in DATA_W data bits on
// bit_en strobes, checks the stop bit and hands the word to a one-entry
// valid/ready buffer.
//
// Parameters:
//   DATA_W     - data bits per frame (2..16)
//   LSB_FIRST  - 1: first data bit lands in dout[0]; 0: in dout[DATA_W-1]
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   bit_en      - bit strobe; din is sampled only when high
//   din         - serial line (idle 1, start 0, stop 1)
//   dout        - received word, valid while dout_valid=1
//   dout_valid  - output buffer holds a word
//   dout_ready  - consumer accepts the word
//   frame_err   - one-cycle pulse: stop bit sampled 0, word discarded
//   overrun     - one-cycle pulse: good word dropped because the buffer was full
module serial_word_rx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              load;
  logic              can_load;

  // Next-state logic. Nothing moves on edges without a strobe.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    load        = 1'b0;

    if (bit_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (din == START_LVL) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end

        ST_DATA: begin
          // Shifting right from the top leaves the first bit in [0] after DATA_W shifts.
          if (LSB_FIRST) begin
            shift_d = {din, shift_q[DATA_W-1:1]};
          end else begin
            shift_d = {shift_q[DATA_W-2:0], din};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_d = ST_STOP;
          end
        end

        ST_STOP: begin
          // The FSM never waits for the consumer; a full buffer drops the word.
          state_d = ST_IDLE;
          if (din == STOP_LVL) begin
            if (can_load) begin
              load = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  rx_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data_in    (shift_q),
    .can_load   (can_load),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  // The two error pulses come from mutually exclusive branches of the stop-bit decision.
  a_pulses_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(frame_err && overrun));

  // A held word must not change until it is taken.
  a_dout_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (dout_valid && !dout_ready) |=> $stable(dout));

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: two instances (LSB-first and MSB-first) share the
// same line. A frame-level reference model (queue of strobed samples) is
// compared against both every cycle; directed vectors cover the listed cases.
module tb_serial_word_rx;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         bit_en;
  logic         din;
  logic         dout_ready;
  logic [W-1:0] a_dout, b_dout;
  logic         a_valid, b_valid;
  logic         a_fe, b_fe;
  logic         a_ov, b_ov;

  serial_word_rx #(.DATA_W(W), .LSB_FIRST(1'b1)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .din        (din),
    .dout       (a_dout),
    .dout_valid (a_valid),
    .dout_ready (dout_ready),
    .frame_err  (a_fe),
    .overrun    (a_ov)
  );

  serial_word_rx #(.DATA_W(W), .LSB_FIRST(1'b0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .din        (din),
    .dout       (b_dout),
    .dout_valid (b_valid),
    .dout_ready (dout_ready),
    .frame_err  (b_fe),
    .overrun    (b_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;
  bit rand_rdy = 1'b0;

  // Reference model: collects strobed samples of the current frame.
  bit           mq[$];
  logic         m_valid;
  logic [W-1:0] m_dout_a, m_dout_b;
  logic         m_fe, m_ov;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid  = 1'b0;
    m_dout_a = '0;
    m_dout_b = '0;
    m_fe     = 1'b0;
    m_ov     = 1'b0;
  endtask

  task automatic model_step();
    bit           acc, xfer, ld;
    logic [W-1:0] wa, wb;
    acc  = !m_valid || dout_ready;
    xfer = m_valid && dout_ready;
    ld   = 1'b0;
    wa   = '0;
    wb   = '0;
    m_fe = 1'b0;
    m_ov = 1'b0;
    if (bit_en) begin
      if (mq.size() == 0) begin
        if (din == 1'b0) mq.push_back(1'b0);
      end else begin
        mq.push_back(din);
        if (mq.size() == W + 2) begin
          for (int i = 0; i < W; i++) begin
            wa[i]     = mq[1 + i];
            wb[W-1-i] = mq[1 + i];
          end
          if (din) begin
            if (acc) ld = 1'b1;
            else m_ov = 1'b1;
          end else begin
            m_fe = 1'b1;
          end
          mq.delete();
        end
      end
    end
    if (ld) begin
      m_valid  = 1'b1;
      m_dout_a = wa;
      m_dout_b = wb;
    end else if (xfer) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic model_compare();
    check("model a_valid", 32'(a_valid), 32'(m_valid));
    check("model b_valid", 32'(b_valid), 32'(m_valid));
    check("model a_fe", 32'(a_fe), 32'(m_fe));
    check("model b_fe", 32'(b_fe), 32'(m_fe));
    check("model a_ov", 32'(a_ov), 32'(m_ov));
    check("model b_ov", 32'(b_ov), 32'(m_ov));
    if (m_valid) begin
      check("model a_dout", 32'(a_dout), 32'(m_dout_a));
      check("model b_dout", 32'(b_dout), 32'(m_dout_b));
    end
  endtask

  // One clock: model follows the rising edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    if (chk_on) model_compare();
  endtask

  // gap idle cycles (junk on din), then one strobed sample.
  task automatic strobe(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      bit_en = 1'b0;
      din    = 1'($urandom_range(0, 1));
      if (rand_rdy) dout_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bit_en = 1'b1;
    din    = b;
    if (rand_rdy) dout_ready = 1'($urandom_range(0, 1));
    tick();
    bit_en = 1'b0;
    din    = 1'b1;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int gap, input bit lsb);
    strobe(1'b0, gap);
    for (int i = 0; i < W; i++) strobe(lsb ? w[i] : w[W-1-i], gap);
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic stop, input int gap,
                            input bit lsb);
    send_bits(w, gap, lsb);
    strobe(stop, gap);
  endtask

  typedef struct {
    logic [W-1:0] word;
    logic         stop;
    logic         rdy;
    logic         rdy_after;
    logic         exp_valid;
    logic [W-1:0] exp_dout;
    logic         exp_fe;
    logic         exp_ov;
    logic         exp_valid_next;
  } vec_t;

  vec_t vecs[5];

  task automatic apply_vec(input int k);
    dout_ready = vecs[k].rdy;
    send_frame(vecs[k].word, vecs[k].stop, 0, 1'b1);
    check($sformatf("vec%0d valid", k), 32'(a_valid), 32'(vecs[k].exp_valid));
    if (vecs[k].exp_valid) check($sformatf("vec%0d dout", k), 32'(a_dout), 32'(vecs[k].exp_dout));
    check($sformatf("vec%0d frame_err", k), 32'(a_fe), 32'(vecs[k].exp_fe));
    check($sformatf("vec%0d overrun", k), 32'(a_ov), 32'(vecs[k].exp_ov));
    dout_ready = vecs[k].rdy_after;
    tick();
    check($sformatf("vec%0d valid_next", k), 32'(a_valid), 32'(vecs[k].exp_valid_next));
    dout_ready = 1'b0;
  endtask

  initial begin
    //         word   stop  rdy   rdy_af valid dout   fe    ov    valid_next
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};

    rst_n      = 1'b1;
    bit_en     = 1'b0;
    din        = 1'b1;
    dout_ready = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;
    repeat (2) tick();
    check("reset dout", 32'(a_dout), 32'h0);
    check("reset valid", 32'(a_valid), 32'h0);
    check("reset pulses", 32'({a_fe, a_ov, b_fe, b_ov}), 32'h0);
    rst_n = 1'b1;

    // Idle line after reset release: nothing may appear.
    for (int i = 0; i < 20; i++) begin
      strobe(1'b1, 0);
      check("idle quiet", 32'({a_valid, a_fe, a_ov}), 32'h0);
    end

    for (int k = 0; k < 3; k++) apply_vec(k);

    // Drain and refill on the same stop-bit edge.
    dout_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 0, 1'b1);
    check("refill first valid", 32'(a_valid), 32'h1);
    send_bits(8'h0F, 0, 1'b1);
    dout_ready = 1'b1;
    strobe(1'b1, 0);
    dout_ready = 1'b0;
    check("refill valid", 32'(a_valid), 32'h1);
    check("refill dout", 32'(a_dout), 32'h0F);
    check("refill overrun", 32'(a_ov), 32'h0);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("refill drained", 32'(a_valid), 32'h0);

    for (int k = 3; k < 5; k++) apply_vec(k);

    // Sparse strobes, MSB-first order on the line.
    dout_ready = 1'b0;
    send_frame(8'hC3, 1'b1, 2, 1'b0);
    check("sparse b_valid", 32'(b_valid), 32'h1);
    check("sparse b_dout", 32'(b_dout), 32'hC3);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;

    // Reset part-way through a frame.
    strobe(1'b0, 0);
    for (int i = 0; i < 4; i++) strobe(1'(i % 2), 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset outputs", 32'({a_valid, a_fe, a_ov, b_valid, b_fe, b_ov}), 32'h0);
    check("midreset dout", 32'(a_dout), 32'h0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    send_frame(8'h96, 1'b1, 0, 1'b1);
    check("post-reset valid", 32'(a_valid), 32'h1);
    check("post-reset dout", 32'(a_dout), 32'h96);
    dout_ready = 1'b1;
    tick();

    // Randomised traffic against the model.
    rand_rdy = 1'b1;
    for (int f = 0; f < 60; f++) begin
      int idle_n;
      idle_n = int'($urandom_range(0, 2));
      for (int i = 0; i < idle_n; i++) strobe(1'b1, int'($urandom_range(0, 2)));
      send_frame(W'($urandom), ($urandom_range(0, 7) != 0), int'($urandom_range(0, 2)),
                 1'b1);
    end
    rand_rdy   = 1'b0;
    dout_ready = 1'b1;
    repeat (3) tick();
    check("final drained", 32'(a_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
